// File: rtl/pending_priority_encoder.sv
// Registered pending-request encoder: latches multi-hot request pulses and
// offers one pending index at a time on a valid/ready handshake.
module pending_priority_encoder #(
  parameter int N  = 16,
  parameter int W  = $clog2(N),
  parameter bit RR = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [N-1:0] req,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] y,
  output logic [N-1:0] pending,
  output logic         dup
);

  logic [N-1:0] pending_q, pending_d;
  logic [N-1:0] clr_mask;
  logic         valid_q, valid_d;
  logic         dup_q, dup_d;
  logic [W-1:0] y_q, y_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] sel_idx;
  logic         sel_found;
  logic [W:0]   cand;
  logic         accept;

  assign accept = valid_q & ready;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_clr_mask
      assign clr_mask[gi] = accept & (y_q == W'(gi));
    end
  endgenerate

  // Set wins over the served-bit clear; clr overrides everything.
  always_comb begin
    pending_d = (pending_q & ~clr_mask) | req;
    dup_d     = |(req & pending_q & ~clr_mask);
    ptr_d     = ptr_q;
    if (RR && accept) begin
      ptr_d = (y_q == W'(N - 1)) ? '0 : y_q + 1'b1;
    end
    if (!RR) begin
      ptr_d = '0;
    end
    if (clr) begin
      pending_d = '0;
      dup_d     = 1'b0;
      ptr_d     = '0;
    end
  end

  // First set bit of pending_d at or after ptr_d, wrapping N-1 -> 0.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_d} + (W + 1)'(k);
      if (cand >= (W + 1)'(N)) begin
        cand = cand - (W + 1)'(N);
      end
      if (!sel_found && pending_d[cand[W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[W-1:0];
      end
    end
  end

  // An outstanding offer is never preempted; it only reloads when idle or taken.
  always_comb begin
    valid_d = valid_q;
    y_d     = y_q;
    if (clr) begin
      valid_d = 1'b0;
      y_d     = '0;
    end else if (!valid_q || accept) begin
      valid_d = sel_found;
      y_d     = sel_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      valid_q   <= 1'b0;
      y_q       <= '0;
      dup_q     <= 1'b0;
      ptr_q     <= '0;
    end else begin
      pending_q <= pending_d;
      valid_q   <= valid_d;
      y_q       <= y_d;
      dup_q     <= dup_d;
      ptr_q     <= ptr_d;
    end
  end

  assign valid   = valid_q;
  assign y       = y_q;
  assign pending = pending_q;
  assign dup     = dup_q;

endmodule

// File: doc/pending_priority_encoder.md
Name: pending_priority_encoder

Overview:
- Parametrised, registered successor to the 16-to-4 combinational encoder.
- Latches multi-hot request pulses into a pending vector and offers one index at a time on a valid/ready handshake.
- Clears each bit once it is served.
- Mode selects fixed priority (lowest index wins) or round-robin.
- Sits between interrupt/event sources and a single consumer that services one index per accept.

Parameters:
- N, 16, number of request lines (N >= 2, not required to be a power of two).
- W, $clog2(N), index width (derived; do not override).
- RR, 0, 0 = fixed priority (bit 0 highest); 1 = round-robin starting after last served index.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush of all state.
- req  in  N  request pulses; each set bit marks that line pending.
- ready  in  1  consumer accepts the offered index this cycle.
- valid  out  1  y holds a pending index.
- y  out  W  offered index.
- pending  out  N  current pending vector.
- dup  out  1  one-cycle pulse: a req bit hit a line already pending and not being cleared.

Behaviour:
- Reset (rst_n=0, async, immediate): pending=0, valid=0, y=0, dup=0, RR pointer ptr=0. All outputs come directly from registers.
- accept = valid & ready. clr_mask = accept ? onehot(y) : 0.
- pending_nxt = (pending & ~clr_mask) | req. Set wins: a bit accepted and re-requested in the same cycle stays pending.
- dup_nxt = |(req & pending & ~clr_mask).
- ptr (RR=1 only): on accept, ptr_nxt = (y == N-1) ? 0 : y+1; otherwise ptr holds. For RR=0, ptr is tied to 0.
- Selection sel(P, p) searches P starting at bit p and wraps N-1 to 0. It returns the first set index. Fixed mode always uses p=0.
- Offer register:
  - if (!valid | accept): valid <= |pending_nxt, y <= sel(pending_nxt, ptr_nxt); y <= 0 when none pending.
  - else (valid & !ready): y and valid hold. A newly arrived higher-priority request does not preempt an outstanding offer.
- Latency: req sampled at edge t gives valid/y at t+1 when idle. Back-to-back accepts serve one index per cycle with no bubble.
- clr=1: pending=0, valid=0, y=0, ptr=0, dup=0 next edge. clr overrides req and accept in the same cycle.
- req bits for an index already offered (valid, not accepted) only merge. dup pulses and no second grant is produced.
- ready while valid=0 is ignored.
- Reset asserted mid-handshake drops all pending requests; there is no recovery of lost requests.

Test Plan:
1. RR=0, N=16: req=16'h8001 for one cycle, ready=1 held → valid=1,y=0 at t+1; y=15 at t+2; valid=0 at t+3; pending=0.
2. RR=0 backpressure: req=16'h0010 at t0, ready=0; req=16'h0002 at t2 → y=4 held through t5; ready=1 at t5 → y=1 at t6, then valid=0.
3. RR=1: req=16'hFFFF one cycle, ready=1 held → y=0,1,...,15 on consecutive cycles, then valid=0. Next, req=16'h0009 every cycle → y alternates 0,3,0,3.
4. Simultaneous set/clear: offer y=5 accepted while req=16'h0020 → pending[5]=1 and y=5 re-offered next cycle, dup=0. req=16'h0020 while y=5 offered with ready=0 → dup=1 for one cycle, one grant only.
5. clr=1 with req=16'hFFFF and valid=1 → next cycle pending=0, valid=0, y=0, dup=0. Under RR=1, the next grant starts from index 0.
6. Async reset: drive rst_n=0 between edges with pending=16'h00F0, valid=1 → valid, y, pending and dup go to 0 immediately without a clock edge. After rst_n=1, req=16'h0100 → y=8 one cycle later.
